// File: rtl/monolith_axis_ip_master_sif_if.sv
// AXI4-Stream master/slave bundle for the Monolith output path.
// Only the stream handshake lives here; clock and reset stay plain ports.
interface monolith_axis_ip_master_sif_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                    tvalid;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;
  logic                    tready;

  modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/monolith_axis_ip_master_sif.sv
// Chunk-to-stream transmitter: buffers whole chunks, emits them word by word on AXIS.
// Optional feature macro: MONOLITH_AXIS_MASTER_PACKET_EN (TLAST once per PACKET_CHUNKS chunks).
module monolith_axis_ip_master_sif #(
  parameter int FIFO_CHUNK_SIZE      = 16,
  parameter int FIFO_CHUNK_COUNT     = 2,
  parameter int PACKET_CHUNKS        = 4,
  parameter int C_M_AXIS_TDATA_WIDTH = 32
) (
  input  logic                            M_AXIS_ACLK,
  input  logic                            M_AXIS_ARESET,
  input  logic                            fifo_write_strobe,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0] fifo_in [0:FIFO_CHUNK_SIZE-1],
  output logic                            fifo_full,
  output logic                            fifo_empty,
  monolith_axis_ip_master_sif_if.master   m_axis
);
  localparam int unsigned WORD_BITS = $clog2(FIFO_CHUNK_SIZE);
  localparam int unsigned SLOT_BITS = $clog2(FIFO_CHUNK_COUNT);
  localparam int unsigned RD_BITS   = WORD_BITS + SLOT_BITS + 1;

  logic [C_M_AXIS_TDATA_WIDTH-1:0] mem [0:FIFO_CHUNK_COUNT-1][0:FIFO_CHUNK_SIZE-1];
  logic [SLOT_BITS:0]   wr_chunk;
  logic [RD_BITS-1:0]   rd_word;
  logic [SLOT_BITS:0]   rd_chunk;
  logic [SLOT_BITS-1:0] wr_slot;
  logic [SLOT_BITS-1:0] rd_slot;
  logic [WORD_BITS-1:0] rd_index;
  logic                 write_en;
  logic                 xfer;
  logic                 last_word;

  assign rd_chunk = rd_word[RD_BITS-1:WORD_BITS];
  assign wr_slot  = wr_chunk[SLOT_BITS-1:0];
  assign rd_slot  = rd_chunk[SLOT_BITS-1:0];
  assign rd_index = rd_word[WORD_BITS-1:0];

  // Full/empty come from pre-edge pointers, so a write coinciding with the
  // freeing of the last slot is rejected.
  assign fifo_full  = (wr_slot == rd_slot) && (wr_chunk[SLOT_BITS] != rd_chunk[SLOT_BITS]);
  assign fifo_empty = (wr_chunk == rd_chunk);
  assign write_en   = fifo_write_strobe && !fifo_full;
  assign xfer       = m_axis.tvalid && m_axis.tready;
  assign last_word  = &rd_index;

  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = mem[rd_slot][rd_index];
  assign m_axis.tstrb  = '1;

  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      for (int unsigned s = 0; s < FIFO_CHUNK_COUNT; s++) begin
        for (int unsigned w = 0; w < FIFO_CHUNK_SIZE; w++) begin
          mem[SLOT_BITS'(s)][WORD_BITS'(w)] <= '0;
        end
      end
    end else if (write_en) begin
      for (int unsigned w = 0; w < FIFO_CHUNK_SIZE; w++) begin
        mem[wr_slot][WORD_BITS'(w)] <= fifo_in[w];
      end
    end
  end

  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      wr_chunk <= '0;
      rd_word  <= '0;
    end else begin
      if (write_en) wr_chunk <= wr_chunk + 1'b1;
      if (xfer)     rd_word  <= rd_word + 1'b1;
    end
  end

`ifdef MONOLITH_AXIS_MASTER_PACKET_EN
  localparam int unsigned PKT_BITS = (PACKET_CHUNKS > 1) ? $clog2(PACKET_CHUNKS) : 1;
  logic [PKT_BITS-1:0] pkt_cnt;

  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      pkt_cnt <= '0;
    end else if (xfer && last_word) begin
      pkt_cnt <= (pkt_cnt == PKT_BITS'(PACKET_CHUNKS - 1)) ? '0 : pkt_cnt + 1'b1;
    end
  end

  assign m_axis.tlast = last_word && (pkt_cnt == PKT_BITS'(PACKET_CHUNKS - 1));
`else
  assign m_axis.tlast = last_word;
`endif
endmodule

// File: tb/tb_monolith_axis_ip_master_sif.sv
// Randomised bench for monolith_axis_ip_master_sif against a queue-based model of the stream.
module tb_monolith_axis_ip_master_sif;
  localparam int SIZE  = 16;
  localparam int COUNT = 2;
  localparam int PKT   = 4;
  localparam int W     = 32;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         strobe = 1'b0;
  logic [W-1:0] chunk_data [0:SIZE-1];
  logic         fifo_full;
  logic         fifo_empty;

  monolith_axis_ip_master_sif_if #(.DATA_WIDTH(W)) axis ();

  monolith_axis_ip_master_sif #(
    .FIFO_CHUNK_SIZE(SIZE),
    .FIFO_CHUNK_COUNT(COUNT),
    .PACKET_CHUNKS(PKT),
    .C_M_AXIS_TDATA_WIDTH(W)
  ) dut (
    .M_AXIS_ACLK(clk),
    .M_AXIS_ARESET(rst),
    .fifo_write_strobe(strobe),
    .fifo_in(chunk_data),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .m_axis(axis)
  );

  always #5 clk = ~clk;

  beat_t        model_q[$];
  logic [W-1:0] sent_q[$];
  logic [W-1:0] log_data[$];
  logic         log_last[$];
  int unsigned  chunks_written = 0;
  int           checks = 0;
  int           errors = 0;
  bit           started = 0;
  bit           prev_stall = 0;
  logic [W-1:0] prev_data;
  logic         prev_last;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned model_slots();
    return (model_q.size() + SIZE - 1) / SIZE;
  endfunction

  function automatic bit chunk_ends_packet(input int unsigned serial);
`ifdef MONOLITH_AXIS_MASTER_PACKET_EN
    return (serial % PKT) == PKT - 1;
`else
    return serial == serial;
`endif
  endfunction

  task automatic model_step();
    bit hs;
    bit acc;
    beat_t b;
    hs  = (model_q.size() != 0) && axis.tready;
    acc = strobe && (model_slots() < COUNT);
    if (hs) void'(model_q.pop_front());
    if (acc) begin
      for (int j = 0; j < SIZE; j++) begin
        b.data = chunk_data[j];
        b.last = (j == SIZE - 1) && chunk_ends_packet(chunks_written);
        model_q.push_back(b);
        sent_q.push_back(chunk_data[j]);
      end
      chunks_written++;
    end
  endtask

  always @(negedge clk) begin
    if (rst || !started) begin
      prev_stall = 0;
    end else begin
      check("tvalid", axis.tvalid, model_q.size() != 0);
      check("fifo_empty", fifo_empty, model_q.size() == 0);
      check("fifo_full", fifo_full, model_slots() == COUNT);
      check("tstrb", axis.tstrb, 4'hF);
      if (model_q.size() != 0) begin
        check("tdata", axis.tdata, model_q[0].data);
        check("tlast", axis.tlast, model_q[0].last);
      end
      if (prev_stall) begin
        check("stall_tvalid", axis.tvalid, 1);
        check("stall_tdata", axis.tdata, prev_data);
        check("stall_tlast", axis.tlast, prev_last);
      end
      if (axis.tvalid && axis.tready) begin
        log_data.push_back(axis.tdata);
        log_last.push_back(axis.tlast);
      end
      prev_stall = axis.tvalid && !axis.tready;
      prev_data  = axis.tdata;
      prev_last  = axis.tlast;
    end
  end

  task automatic fill(input logic [W-1:0] base);
    for (int i = 0; i < SIZE; i++) chunk_data[i] = base + W'(i);
  endtask

  task automatic step(input bit s, input bit r);
    strobe = s;
    axis.tready = r;
    @(posedge clk);
    if (!rst) model_step();
    #1;
    strobe = 0;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (model_q.size() != 0 && n < max_cycles) begin
      step(0, 1);
      n++;
    end
    check("drain_bound", model_q.size() != 0, 0);
    check("drain_empty", fifo_empty, 1);
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    check("rst_tvalid", axis.tvalid, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_tdata", axis.tdata, 0);
    check("rst_tlast", axis.tlast, 0);
    check("rst_tstrb", axis.tstrb, 4'hF);
    model_q.delete();
    chunks_written = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    log_data.delete();
    log_last.delete();
  endtask

  initial begin
    int n;
    int cnt;
    axis.tready = 0;
    fill('0);
    #1;
    do_reset();
    started = 1;

    // Single chunk, TREADY high
    fill(32'h100);
    step(1, 1);
    check("t1_latency_tvalid", axis.tvalid, 1);
    check("t1_latency_tdata", axis.tdata, 32'h100);
    drain(40);
    check("t1_beats", log_data.size(), 16);
    check("t1_first", log_data[0], 32'h100);
    check("t1_lastword", log_data[15], 32'h10F);
    cnt = 0;
    foreach (log_last[i]) if (log_last[i]) cnt++;
    check("t1_tlast_count", cnt, 1);
    check("t1_tlast_pos", log_last[15], 1);

    // Fill with TREADY low, dropped third strobe
    log_data.delete(); log_last.delete();
    fill(32'h200); step(1, 0);
    fill(32'h210); step(1, 0);
    check("t2_full", fifo_full, 1);
    fill(32'hDEAD0000); step(1, 0);
    check("t2_still_full", fifo_full, 1);
    step(0, 0);
    drain(80);
    check("t2_beats", log_data.size(), 32);
    check("t2_second_chunk", log_data[16], 32'h210);
    cnt = 0;
    foreach (log_data[i]) if (log_data[i][31:16] == 16'hDEAD) cnt++;
    check("t2_dead_dropped", cnt, 0);

    // Strobe on the edge that frees a slot is rejected, next one accepted
    log_data.delete(); log_last.delete();
    fill(32'h300); step(1, 0);
    fill(32'h310); step(1, 0);
    n = 0;
    while (model_q.size() != SIZE + 1 && n < 100) begin step(0, 1); n++; end
    check("t3_reach_bound", model_q.size(), SIZE + 1);
    check("t3_full_before", fifo_full, 1);
    fill(32'h320); step(1, 1);
    fill(32'h330); step(1, 1);
    drain(100);
    check("t3_beats", log_data.size(), 48);
    check("t3_d_first", log_data[32], 32'h330);
    check("t3_d_last", log_data[47], 32'h33F);
    cnt = 0;
    foreach (log_data[i]) if (log_data[i][31:4] == 28'h32) cnt++;
    check("t3_c_dropped", cnt, 0);

    // Reset mid-chunk
    fill(32'h600); step(1, 1);
    repeat (5) step(0, 1);
    check("t6_mid_beats", log_data.size(), 53);
    do_reset();
    fill(32'h700); step(1, 1);
    drain(40);
    check("t6_beats", log_data.size(), 16);
    check("t6_first", log_data[0], 32'h700);

    // Random throttling over 8 chunks
    do_reset();
    sent_q.delete();
    n = 0;
    while ((chunks_written < 8 || model_q.size() != 0) && n < 3000) begin
      bit s;
      s = (chunks_written < 8) && ($urandom % 2 == 1);
      if (s) foreach (chunk_data[i]) chunk_data[i] = $urandom;
      step(s, $urandom % 2 == 1);
      n++;
    end
    check("t4_bound", n < 3000, 1);
    check("t4_beats", log_data.size(), 128);
    check("t4_sent", sent_q.size(), 128);
    if (log_data.size() == 128 && sent_q.size() == 128) begin
      for (int i = 0; i < 128; i++) check("t4_order", log_data[i], sent_q[i]);
      cnt = 0;
      foreach (log_last[i]) if (log_last[i]) cnt++;
`ifdef MONOLITH_AXIS_MASTER_PACKET_EN
      check("t5_tlast_count", cnt, 2);
      check("t5_tlast_64", log_last[63], 1);
      check("t5_tlast_128", log_last[127], 1);
      check("t5_no_tlast_16", log_last[15], 0);
`else
      check("t4_tlast_count", cnt, 8);
      check("t4_tlast_16", log_last[15], 1);
      check("t4_tlast_128", log_last[127], 1);
      check("t4_no_tlast_14", log_last[14], 0);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/monolith_axis_ip_master_sif.md
# monolith_axis_ip_master_sif

Chunk-to-stream transmitter for the Monolith accelerator's output path. The hash core deposits one whole result chunk of FIFO_CHUNK_SIZE words in a single cycle. The block buffers up to FIFO_CHUNK_COUNT chunks and serialises them word by word onto an AXI4-Stream master port toward the DMA. It is the transmit counterpart of the slave stream interface that feeds the core.

## Interface
Parameters:
- FIFO_CHUNK_SIZE, 16: words per chunk; power of two, ≥2.
- FIFO_CHUNK_COUNT, 2: chunk slots buffered; power of two, ≥2.
- PACKET_CHUNKS, 4: chunks per AXIS packet. Used only with MONOLITH_AXIS_MASTER_PACKET_EN.
- C_M_AXIS_TDATA_WIDTH, 32: stream word width; multiple of 8.

Ports:
- M_AXIS_ACLK  in  1  sole clock; all state updates on rising edge.
- M_AXIS_ARESET  in  1  asynchronous, active-high reset.
- fifo_write_strobe  in  1  request to push fifo_in as one chunk.
- fifo_in  in  C_M_AXIS_TDATA_WIDTH × [0:FIFO_CHUNK_SIZE-1]  chunk words; index 0 is sent first.
- fifo_full  out  1  all chunk slots occupied.
- fifo_empty  out  1  no unsent words.
- M_AXIS_TVALID  out  1  word available.
- M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  current word.
- M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  constant all-ones.
- M_AXIS_TLAST  out  1  packet boundary.
- M_AXIS_TREADY  in  1  sink accepts.

## Operation
- Storage: FIFO_CHUNK_COUNT×FIFO_CHUNK_SIZE registered words, reset to 0.
- wr_chunk pointer: log2(FIFO_CHUNK_COUNT)+1 bits, including a wrap bit.
- rd_word pointer: log2(total words)+1 bits, including a wrap bit.
- Write: when fifo_write_strobe && !fifo_full, all FIFO_CHUNK_SIZE words are written to slot wr_chunk[low bits] in parallel, and wr_chunk increments.
- A strobe while fifo_full is dropped silently, with no state change.
- fifo_full: the low bits of wr_chunk equal the chunk index of rd_word, and the wrap bits differ.
- fifo_empty: wr_chunk equals the upper bits of rd_word.
- M_AXIS_TVALID = !fifo_empty.
- M_AXIS_TDATA = word at rd_word (combinational mux).
- Transfer occurs on TVALID && TREADY; rd_word then increments and wraps through its wrap bit.
- A chunk slot is freed when its last word transfers.
- TLAST (default build): asserted while the current word is index FIFO_CHUNK_SIZE-1 of its chunk.
- States are implicit in the pointers:
  - EMPTY: fifo_empty=1.
  - STREAMING: 0 < occupancy < FIFO_CHUNK_COUNT.
  - FULL: fifo_full=1.
- Occupancy changes by +1 chunk on an accepted write and by −1 chunk on transfer of the last word of a chunk.

## Timing
- Reset, asynchronous: pointers 0, storage 0, fifo_empty=1, fifo_full=0, TVALID=0, TDATA=0, TLAST=0, TSTRB all-ones. Release is synchronous to the next edge.
- Latency: a chunk written at edge N yields TVALID=1 in the cycle after N, with word 0 on TDATA.
- Throughput: 1 word/cycle with TREADY held high. No bubble between consecutive chunks.
- AXIS rule: once TVALID=1, TVALID, TDATA and TLAST stay stable until the handshake. Writes never modify the slot being read.
- Simultaneous write and last-word read while full: the write is rejected, because fifo_full is evaluated before the read. The slot frees at that edge, and the next strobe is accepted.
- Simultaneous write and read while not full: both take effect at the same edge.
- Reset mid-packet: the stream aborts with no TLAST. All buffered chunks are discarded.

## Configuration
- MONOLITH_AXIS_MASTER_PACKET_EN defined:
  - A packet counter (log2(PACKET_CHUNKS) bits, reset 0) increments on each transfer of a chunk's last word and wraps at PACKET_CHUNKS.
  - TLAST is asserted only on the last word of a chunk whose packet-counter value is PACKET_CHUNKS-1.
  - The counter is cleared by reset only.
- Not defined: TLAST is asserted on the last word of every chunk, and PACKET_CHUNKS is ignored.

## Test plan
- Reset, then write chunk 0x100..0x10F with TREADY=1 → TVALID rises the next cycle; 16 consecutive beats carry 0x100..0x10F; TLAST only on 0x10F; fifo_empty=1 afterwards.
- Two writes with TREADY=0 → fifo_full=1. A third strobe with 0xDEAD.. is dropped. Then 32 beats with TREADY=1 carry only the first two chunks.
- Full buffer, strobe on the same edge as the last-word transfer of chunk 0 → write ignored; a strobe one cycle later is accepted and streamed after chunk 1.
- Random TREADY throttling (50%) over 8 chunks → every word delivered exactly once, in order. TDATA and TLAST stay stable during stalls.
- With MONOLITH_AXIS_MASTER_PACKET_EN and PACKET_CHUNKS=4, stream 8 chunks → TLAST only on beats 64 and 128.
- Assert M_AXIS_ARESET after beat 5 of a chunk → TVALID=0 immediately (asynchronously); after release, fifo_empty=1 and a new chunk streams from word 0.
